counter_reader: RTL



---
 rtl/counter_reader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/counter_reader.sv
// Bus-side reader for the free-running 32-bit cycle counter: 64-bit extension,
// tear-free LO/HI read pair, and a 64-bit compare that drives a level interrupt.
module counter_reader #(
    parameter int          ADDR_W  = 5,
    parameter logic [63:0] RST_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       hc_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              irq
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [ADDR_W-3:0] W_CNT_LO = (ADDR_W-2)'(0);
    localparam logic [ADDR_W-3:0] W_CNT_HI = (ADDR_W-2)'(1);
    localparam logic [ADDR_W-3:0] W_CMP_LO = (ADDR_W-2)'(2);
    localparam logic [ADDR_W-3:0] W_CMP_HI = (ADDR_W-2)'(3);
    localparam logic [ADDR_W-3:0] W_CTRL   = (ADDR_W-2)'(4);

    state_t            state;
    logic [31:0]       prev_hc;
    logic [31:0]       ext_hi;
    logic [31:0]       shadow_hi;
    logic [63:0]       cmp;
    logic              irq_en;
    logic              pending;

    logic              wrap;
    logic [63:0]       cnt64;
    logic              match;
    logic              accept;
    logic              wr_en;
    logic              rd_lo;
    logic              w1c;
    logic [ADDR_W-3:0] word;
    logic [31:0]       acc_rdata;
    logic              acc_err;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    always_comb begin
        wrap   = hc_in < prev_hc;
        // Include the wrap of this very cycle so the count never steps backwards.
        cnt64  = {ext_hi + 32'(wrap), hc_in};
        match  = cnt64 >= cmp;
        accept = req_valid && req_ready;
        word   = req_addr[ADDR_W-1:2];
        wr_en  = accept && req_we;
        rd_lo  = accept && !req_we && (word == W_CNT_LO);
        w1c    = wr_en && (word == W_CTRL) && req_wdata[1];

        acc_rdata = '0;
        acc_err   = 1'b0;
        case (word)
            W_CNT_LO: acc_rdata = req_we ? '0 : cnt64[31:0];
            W_CNT_HI: acc_rdata = req_we ? '0 : shadow_hi;
            W_CMP_LO: acc_rdata = req_we ? '0 : cmp[31:0];
            W_CMP_HI: acc_rdata = req_we ? '0 : cmp[63:32];
            W_CTRL:   acc_rdata = req_we ? '0 : {30'd0, pending, irq_en};
            default:  acc_err   = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            irq        <= 1'b0;
            prev_hc    <= '0;
            ext_hi     <= '0;
            shadow_hi  <= '0;
            cmp        <= RST_CMP;
            irq_en     <= 1'b0;
            pending    <= 1'b0;
        end else begin
            prev_hc <= hc_in;
            if (wrap) begin
                ext_hi <= ext_hi + 32'd1;
            end

            // Set has priority over a same-cycle write-one-to-clear.
            pending <= match || (pending && !w1c);
            irq     <= pending && irq_en;

            if (rd_lo) begin
                shadow_hi <= cnt64[63:32];
            end
            if (wr_en) begin
                case (word)
                    W_CMP_LO: cmp[31:0]  <= req_wdata;
                    W_CMP_HI: cmp[63:32] <= req_wdata;
                    W_CTRL:   irq_en     <= req_wdata[0];
                    default:  ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        resp_rdata <= acc_rdata;
                        resp_err   <= acc_err;
                        resp_valid <= 1'b1;
                        req_ready  <= 1'b0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
